// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_skid
// Purpose  : Pipeline stage register with valid/ready handshake, 2-entry skid
//            buffer, synchronous flush, bubble-masked control field and a
//            saturating bubble counter.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_skid #(
  parameter int CTRL_W = 9,
  parameter int DATA_W = 111,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt
);

  // Occupancy doubles as the state encoding.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic                in_ready_q;
  logic                out_valid_q;
  logic [CNT_W-1:0]    bubble_q, bubble_d;
  logic                in_fire;
  logic                out_fire;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  // Next-state and storage steering; flush wins over every handshake move.
  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
            state_d     = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (in_fire) begin
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
            state_d     = FULL;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            state_d     = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    // Held control is scrubbed whenever the stage goes empty.
    if (state_d == EMPTY) begin
      main_ctrl_d = '0;
    end
  end

  // Bubble counter: counts cycles with no valid output, saturating.
  always_comb begin
    bubble_d = bubble_q;
    if (!out_valid_q && (bubble_q != {CNT_W{1'b1}})) begin
      bubble_d = bubble_q + 1'b1;
    end
  end

  // State, payload and handshake registers; ready/valid are precomputed from
  // the next state so no combinational path reaches in_ready.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      bubble_q    <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      in_ready_q  <= (state_d != FULL);
      out_valid_q <= (state_d != EMPTY);
      bubble_q    <= bubble_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_ctrl   = out_valid_q ? main_ctrl_q : '0;
  assign out_data   = main_data_q;
  assign occupancy  = state_q;
  assign bubble_cnt = bubble_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_skid
// Purpose  : Directed self-checking bench for pipe_stage_skid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_skid;

  localparam int CTRL_W = 9;
  localparam int DATA_W = 111;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  bubble_cnt;

  int n_chk;
  int n_pass;

  pipe_stage_skid #(
    .CTRL_W(CTRL_W),
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .occupancy (occupancy),
    .bubble_cnt(bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk = n_chk + 1;
    if (act === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one clock edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
    in_valid = v;
    in_ctrl  = c;
    in_data  = d;
  endtask

  initial begin
    n_chk     = 0;
    n_pass    = 0;
    rst       = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 9'h1FF, 111'hA5);

    // Reset held two edges with in_valid asserted.
    step();
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_ctrl", out_ctrl, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_bubble", bubble_cnt, 0);

    // First entry after release shows up one cycle later.
    rst = 1'b1;
    step();
    chk("first_valid", out_valid, 1);
    chk("first_ctrl", out_ctrl, 9'h1FF);
    chk("first_data", out_data, 111'hA5);
    chk("first_bubble", bubble_cnt, 1);

    // Consumed, no new input: bubble masks ctrl, data retained.
    drive(1'b0, 9'h0, 111'h0);
    step();
    chk("bub_valid", out_valid, 0);
    chk("bub_ctrl", out_ctrl, 0);
    chk("bub_data", out_data, 111'hA5);
    chk("bub_occ", occupancy, 0);
    chk("bub_cnt0", bubble_cnt, 1);
    step();
    step();
    step();
    chk("bub_cnt3", bubble_cnt, 4);

    // Saturation of the 4-bit counter.
    for (int i = 0; i < 20; i++) step();
    chk("bub_sat", bubble_cnt, 15);
    chk("bub_sat_ctrl", out_ctrl, 0);

    // Streaming 1..8 with out_ready high.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, CTRL_W'(i), DATA_W'(i));
      step();
      chk($sformatf("strm_data%0d", i), out_data, i);
      chk($sformatf("strm_ctrl%0d", i), out_ctrl, i);
      chk($sformatf("strm_rdy%0d", i), in_ready, 1);
      chk($sformatf("strm_occ%0d", i), occupancy, 1);
    end
    drive(1'b0, 9'h0, 111'h0);
    step();
    chk("strm_end_valid", out_valid, 0);
    chk("strm_end_occ", occupancy, 0);
    chk("strm_end_sat", bubble_cnt, 15);

    // Back-pressure: 10 and 11 accepted, 12 held upstream.
    out_ready = 1'b0;
    drive(1'b1, 9'h0A, 111'd10);
    step();
    chk("bp_occ1", occupancy, 1);
    chk("bp_rdy1", in_ready, 1);
    chk("bp_data1", out_data, 10);
    drive(1'b1, 9'h0B, 111'd11);
    step();
    chk("bp_occ2", occupancy, 2);
    chk("bp_rdy2", in_ready, 0);
    chk("bp_data2", out_data, 10);
    drive(1'b1, 9'h0C, 111'd12);
    step();
    chk("bp_hold_occ", occupancy, 2);
    chk("bp_hold_data", out_data, 10);
    chk("bp_hold_ctrl", out_ctrl, 9'h0A);
    chk("bp_hold_valid", out_valid, 1);
    out_ready = 1'b1;
    step();
    chk("bp_drain11", out_data, 11);
    chk("bp_drain11_ctrl", out_ctrl, 9'h0B);
    chk("bp_drain_occ", occupancy, 1);
    chk("bp_drain_rdy", in_ready, 1);
    step();
    chk("bp_drain12", out_data, 12);
    chk("bp_drain12_valid", out_valid, 1);
    drive(1'b0, 9'h0, 111'h0);
    step();
    chk("bp_empty", out_valid, 0);

    // Flush with two entries held and an input offered.
    out_ready = 1'b0;
    drive(1'b1, 9'h14, 111'd20);
    step();
    drive(1'b1, 9'h15, 111'd21);
    step();
    chk("fl_pre_occ", occupancy, 2);
    flush = 1'b1;
    drive(1'b1, 9'h1FF, 111'h33);
    step();
    chk("fl_valid", out_valid, 0);
    chk("fl_ctrl", out_ctrl, 0);
    chk("fl_occ", occupancy, 0);
    chk("fl_rdy", in_ready, 1);
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 9'h0, 111'h0);
    step();
    chk("fl_no_ghost", out_valid, 0);

    // Flush while an input is actually accepted: it must be discarded.
    out_ready = 1'b0;
    drive(1'b1, 9'h28, 111'd40);
    step();
    chk("fl1_occ", occupancy, 1);
    flush = 1'b1;
    drive(1'b1, 9'h1FF, 111'h33);
    step();
    flush = 1'b0;
    drive(1'b0, 9'h0, 111'h0);
    chk("fl1_occ0", occupancy, 0);
    step();
    chk("fl1_valid", out_valid, 0);
    chk("fl1_data", out_data, 40);

    // Reset mid-transfer drops held entries.
    drive(1'b1, 9'h1, 111'd50);
    step();
    drive(1'b1, 9'h2, 111'd51);
    step();
    rst = 1'b0;
    step();
    chk("rst2_occ", occupancy, 0);
    chk("rst2_valid", out_valid, 0);
    chk("rst2_data", out_data, 0);
    chk("rst2_bubble", bubble_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline stage register with valid/ready handshake, a 2-entry skid buffer, synchronous flush and bubble-safe control clearing. It generalises the fixed-field stage registers between pipeline stages (ID/EX and later): the payload is split into a control field (write/read enables etc., forced to zero on bubbles) and a data field (operands, immediates, register indices). The block adds back-pressure without a combinational ready path, and adds a saturating bubble counter for performance debug.

## Interface
Parameters:
- CTRL_W, 9, width of control field; cleared whenever the stage holds no valid entry
- DATA_W, 111, width of data field (e.g. 3×32 operands + 3×5 register indices)
- CNT_W, 16, width of bubble counter

Ports:
- clk  in  1  rising-edge clock, single clock domain
- rst  in  1  synchronous reset, active-low (rst==0 at a rising clk edge resets)
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  upstream has an entry
- in_ready  out  1  stage can accept; registered, no combinational path from out_ready
- in_ctrl  in  CTRL_W  control field of incoming entry
- in_data  in  DATA_W  data field of incoming entry
- out_valid  out  1  out_ctrl/out_data hold a valid entry
- out_ready  in  1  downstream consumes entry
- out_ctrl  out  CTRL_W  control field; all-zero when out_valid==0
- out_data  out  DATA_W  data field
- occupancy  out  2  entries held: 0, 1 or 2
- bubble_cnt  out  CNT_W  saturating count of cycles with out_valid==0

## Operation
- Storage: main register (drives outputs) and skid register. in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- States (encoded by occupancy): EMPTY(0), ONE(1), FULL(2). in_ready = (state != FULL).
- EMPTY: in_fire -> main<=in, ONE; else stay.
- ONE: in_fire & out_fire -> main<=in, ONE; in_fire only -> skid<=in, FULL; out_fire only -> EMPTY; neither -> hold.
- FULL: out_fire -> main<=skid, ONE (in_ready is 0, no input accepted); else hold.
- Order preserved: skid entry is always younger than main entry.
- flush (rst high): next state EMPTY, out_valid 0, skid discarded; any in_fire in the same cycle is discarded (upstream sees it accepted). flush overrides all transitions.
- out_ctrl = main_ctrl when out_valid else 0 (bubbles never assert write/read enables). out_data retains last value when invalid; not cleared by flush.
- bubble_cnt increments by 1 each cycle out_valid==0 (sampled pre-edge), saturates at 2^CNT_W-1; cleared only by reset.
- Reset (rst==0): state EMPTY, in_ready 1, out_valid 0, out_ctrl 0, out_data 0, skid contents 0, occupancy 0, bubble_cnt 0. Reset overrides flush and handshakes; reset mid-transfer drops all entries.

## Timing
- Latency: entry accepted at edge N appears on out_* after edge N (visible in cycle N+1).
- Throughput: 1 entry/cycle sustained while out_ready==1; never stalls upstream unless two entries held.
- in_ready deasserts the cycle after entering FULL, reasserts the cycle after the draining out_fire.
- out_valid/out_data stable while out_valid & !out_ready (no change until consumed or flushed).
- All outputs are register outputs except out_ctrl (AND of register and out_valid register).
- Flush at edge N: out_valid==0, occupancy==0, in_ready==1 in cycle N+1.

## Test plan
- Reset: hold rst=0 2 cycles with in_valid=1 -> out_valid=0, out_ctrl=0, out_data=0, occupancy=0, in_ready=1, bubble_cnt=0; release -> first in_valid entry (ctrl=0x1FF, data=0xA5) on outputs 1 cycle later.
- Streaming: out_ready=1, send 8 entries back-to-back with data 1..8 -> out_data 1..8 on consecutive cycles, in_ready constantly 1, occupancy 1.
- Back-pressure: out_ready=0, send 3 entries (10,11,12) -> 10 and 11 accepted, occupancy 2, in_ready 0, 12 held upstream; raise out_ready -> outputs 10,11,12 in order, no loss/duplication.
- Flush: occupancy 2, assert flush with in_valid=1 (data 0x33) -> next cycle out_valid 0, out_ctrl 0, occupancy 0; 0x33 never appears at output.
- Bubble control clearing: main holds ctrl=0x1FF, downstream consumes, no new input -> out_valid 0 and out_ctrl 0 while out_data keeps last value; bubble_cnt increments each idle cycle.
- Counter saturation (CNT_W=4): idle 20 cycles after reset -> bubble_cnt stops at 15.
